// File: rtl/hartslag_pkg.sv
// Shared defaults and helpers for the hartslag heartbeat rate meter.
package hartslag_pkg;

    localparam int DEF_CNT_W         = 8;
    localparam int DEF_WINDOW_CYCLES = 50_000_000;  // 1 s at 50 MHz
    localparam int DEF_DEB_CYCLES    = 1000;
    localparam int DEF_SYNC_STAGES   = 2;

    // Window counter width; never narrower than one bit.
    function automatic int win_cnt_w(input int cycles);
        int w;
        w = $clog2(cycles);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/hartslag_kanaal.sv
// One heartbeat channel: synchroniser, optional debounce (HARTSLAG_DEBOUNCE_EN),
// rising-edge detect, saturating beat counter and sticky saturation flag.
module hartslag_kanaal
    import hartslag_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
`ifdef HARTSLAG_DEBOUNCE_EN
    , parameter int DEB_CYCLES = DEF_DEB_CYCLES
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ingang_i,
    input  logic             term_i,
    input  logic             clear_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             ovf_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   lvl_q, lvl_d;
    logic                   lvl_dly_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_fin;
    logic                   sat_q, sat_d, sat_fin;
    logic                   rise, at_max;

    assign s = sync_q[SYNC_STAGES-1];

`ifdef HARTSLAG_DEBOUNCE_EN
    localparam int DW = $clog2(DEB_CYCLES + 1);
    logic [DW-1:0] deb_q, deb_d;

    // lvl follows s only after s has differed from lvl for DEB_CYCLES+1 samples.
    always_comb begin
        deb_d = '0;
        lvl_d = lvl_q;
        if (s != lvl_q) begin
            if (deb_q == DW'(DEB_CYCLES))
                lvl_d = s;
            else
                deb_d = deb_q + DW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) deb_q <= '0;
        else        deb_q <= deb_d;
    end
`else
    assign lvl_d = s;
`endif

    always_comb begin
        rise    = lvl_q & ~lvl_dly_q;
        at_max  = &cnt_q;
        cnt_fin = cnt_q + CNT_W'(rise & ~at_max);
        sat_fin = sat_q | (rise & at_max);
        cnt_d   = cnt_fin;
        sat_d   = sat_fin;
        // Clear drops any beat of this cycle; terminal hands it to the output first.
        if (clear_i || term_i) begin
            cnt_d = '0;
            sat_d = 1'b0;
        end
    end

    assign cnt_o = cnt_fin;
    assign ovf_o = sat_fin;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= '0;
            lvl_q     <= 1'b0;
            lvl_dly_q <= 1'b0;
            cnt_q     <= '0;
            sat_q     <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], ingang_i};
            lvl_q     <= lvl_d;
            lvl_dly_q <= lvl_q;
            cnt_q     <= cnt_d;
            sat_q     <= sat_d;
        end
    end

endmodule

// File: rtl/hartslag_meter.sv
// Multi-channel heartbeat rate meter: window counter, per-channel counters and
// latched per-window results. Debounce is compiled in with HARTSLAG_DEBOUNCE_EN.
module hartslag_meter
    import hartslag_pkg::*;
#(
    parameter int CHANNELS      = 2,
    parameter int CNT_W         = DEF_CNT_W,
    parameter int WINDOW_CYCLES = DEF_WINDOW_CYCLES,
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int DEB_CYCLES    = DEF_DEB_CYCLES
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       ingang,
    input  logic                      clear,
    output logic [CHANNELS*CNT_W-1:0] out,
    output logic                      out_valid,
    output logic [CHANNELS-1:0]       overflow
);

    localparam int              WC_W    = win_cnt_w(WINDOW_CYCLES);
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(WINDOW_CYCLES - 1);

    if (CHANNELS < 1 || WINDOW_CYCLES < 2 || SYNC_STAGES < 2 || DEB_CYCLES < 1) begin : g_bad_cfg
        $error("hartslag_meter: illegal parameter set");
    end

    logic [WC_W-1:0]           wc_q, wc_d;
    logic                      term;
    logic [CHANNELS*CNT_W-1:0] fin_cnt;
    logic [CHANNELS-1:0]       fin_ovf;
    logic [CHANNELS*CNT_W-1:0] out_q, out_d;
    logic [CHANNELS-1:0]       ovf_q, ovf_d;
    logic                      vld_q, vld_d;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        hartslag_kanaal #(
            .CNT_W       (CNT_W),
            .SYNC_STAGES (SYNC_STAGES)
`ifdef HARTSLAG_DEBOUNCE_EN
            , .DEB_CYCLES (DEB_CYCLES)
`endif
        ) u_ch (
            .clk      (clk),
            .rst_n    (reset),
            .ingang_i (ingang[c]),
            .term_i   (term),
            .clear_i  (clear),
            .cnt_o    (fin_cnt[c*CNT_W +: CNT_W]),
            .ovf_o    (fin_ovf[c])
        );
    end

    always_comb begin
        term  = (wc_q == WC_LAST);
        wc_d  = wc_q + WC_W'(1);
        out_d = out_q;
        ovf_d = ovf_q;
        vld_d = 1'b0;
        if (clear || term)
            wc_d = '0;
        // Clear outranks the terminal cycle: that window is simply abandoned.
        if (term && !clear) begin
            out_d = fin_cnt;
            ovf_d = fin_ovf;
            vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wc_q  <= '0;
            out_q <= '0;
            ovf_q <= '0;
            vld_q <= 1'b0;
        end else begin
            wc_q  <= wc_d;
            out_q <= out_d;
            ovf_q <= ovf_d;
            vld_q <= vld_d;
        end
    end

    assign out       = out_q;
    assign overflow  = ovf_q;
    assign out_valid = vld_q;

endmodule

// File: tb/tb_hartslag_meter.sv
// Directed bench for hartslag_meter: CHANNELS=2, CNT_W=4, WINDOW_CYCLES=100.
module tb_hartslag_meter;

    localparam int CH = 2;
    localparam int CW = 4;
`ifdef HARTSLAG_DEBOUNCE_EN
    localparam int       LAT     = 7;
    localparam int       S2_N    = 9;
    localparam int       S2_HW   = 5;
    localparam bit [7:0] S2_OUT  = 8'h90;
    localparam bit [1:0] S2_OVF  = 2'b00;
    localparam bit [7:0] GL_OUT  = 8'h20;
`else
    localparam int       LAT     = 3;
    localparam int       S2_N    = 20;
    localparam int       S2_HW   = 2;
    localparam bit [7:0] S2_OUT  = 8'hF0;
    localparam bit [1:0] S2_OVF  = 2'b10;
    localparam bit [7:0] GL_OUT  = 8'h23;
`endif

    logic             clk;
    logic             reset;
    logic [CH-1:0]    ingang;
    logic             clear;
    logic [CH*CW-1:0] out;
    logic             out_valid;
    logic [CH-1:0]    overflow;

    int cyc     = 0;
    int n_pass  = 0;
    int n_total = 0;

    hartslag_meter #(
        .CHANNELS      (CH),
        .CNT_W         (CW),
        .WINDOW_CYCLES (100),
        .SYNC_STAGES   (2),
        .DEB_CYCLES    (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ingang    (ingang),
        .clear     (clear),
        .out       (out),
        .out_valid (out_valid),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic pulses(input int ch, input int n, input int hi, input int lo);
        for (int p = 0; p < n; p++) begin
            ingang[ch] = 1'b1;
            repeat (hi) step();
            ingang[ch] = 1'b0;
            repeat (lo) step();
        end
    endtask

    // Bounded wait for the next out_valid, then check when and what it delivered.
    task automatic wait_valid(input string tag, input int exp_cyc,
                              input logic [7:0] exp_out, input logic [1:0] exp_ovf);
        while (out_valid !== 1'b1 && cyc < exp_cyc + 20) step();
        chk({tag, ".vld"}, 32'(out_valid), 32'd1);
        chk({tag, ".cyc"}, cyc, exp_cyc);
        chk({tag, ".out"}, 32'(out), 32'(exp_out));
        chk({tag, ".ovf"}, 32'(overflow), 32'(exp_ovf));
    endtask

    initial begin
        reset  = 1'b0;
        ingang = '0;
        clear  = 1'b0;
        repeat (3) step();
        chk("rst.out", 32'(out), 32'h0);
        chk("rst.ovf", 32'(overflow), 32'h0);
        chk("rst.vld", 32'(out_valid), 32'h0);
        reset = 1'b1;
        cyc   = 0;

        // Window 1: 7 clean pulses on ch0
        pulses(0, 7, 5, 5);
        wait_valid("w1", 100, 8'h07, 2'b00);
        step();
        chk("w1.vld_pulse", 32'(out_valid), 32'h0);
        chk("w1.hold", 32'(out), 32'h07);

        // Window 2: ch1 saturates; window 3 recovers
        pulses(1, S2_N, S2_HW, S2_HW);
        wait_valid("w2", 200, S2_OUT, S2_OVF);
        pulses(1, 3, 5, 5);
        wait_valid("w3", 300, 8'h30, 2'b00);

        // Window 4: last beat lands on the terminal cycle
        pulses(0, 2, 5, 5);
        while (cyc < 399 - LAT) step();
        ingang[0] = 1'b1;
        while (cyc < 400) step();
        wait_valid("term", 400, 8'h03, 2'b00);
        step();
        ingang[0] = 1'b0;
        pulses(1, 2, 5, 5);
        wait_valid("after_term", 500, 8'h20, 2'b00);

        // Window 6: clear mid-window drops the 4 earlier beats
        pulses(0, 4, 5, 5);
        while (cyc < 559) step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clr.vld", 32'(out_valid), 32'h0);
        chk("clr.hold", 32'(out), 32'h20);
        pulses(0, 2, 5, 5);
        while (cyc < 600) step();
        chk("clr.no_vld600", 32'(out_valid), 32'h0);
        chk("clr.hold600", 32'(out), 32'h20);
        wait_valid("clr", 660, 8'h02, 2'b00);

        // Reset mid-window; ch1 held high across release counts once
        pulses(0, 3, 5, 5);
        while (cyc < 710) step();
        reset     = 1'b0;
        ingang[1] = 1'b1;
        #1;
        chk("mrst.out", 32'(out), 32'h0);
        chk("mrst.ovf", 32'(overflow), 32'h0);
        chk("mrst.vld", 32'(out_valid), 32'h0);
        step();
        step();
        reset = 1'b1;
        cyc   = 0;
        wait_valid("mrst", 100, 8'h10, 2'b00);
        ingang[1] = 1'b0;

        // Glitches on ch0, wide pulses on ch1
        pulses(0, 3, 2, 8);
        pulses(1, 2, 10, 10);
        wait_valid("glitch", 200, GL_OUT, 2'b00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/hartslag_meter.md
# hartslag_meter

Parametrised multi-channel heartbeat rate meter. It samples CHANNELS asynchronous pulse inputs from the heartbeat sensors and counts rising edges per channel over a fixed measurement window. At the end of each window it latches all counts to the outputs together with a valid strobe. It sits between the sensor input pins and the rocking-control logic, and replaces the single-channel counter that relied on a separate window clock.

## Interface
- CHANNELS, 2, number of independent sensor inputs (≥1)
- CNT_W, 8, width of each per-channel beat count
- WINDOW_CYCLES, 50_000_000, clk cycles per measurement window (≥2)
- SYNC_STAGES, 2, synchroniser flops per input (≥2)
- DEB_CYCLES, 1000, debounce stability length in clk cycles (≥1; used only with debounce compiled in)

- clk  in  1  sole clock. One clock; reset is asynchronous and active-low.
- reset  in  1  asynchronous, active-low reset.
- ingang  in  CHANNELS  raw sensor pulses, asynchronous to clk.
- clear  in  1  synchronous restart: window counter and beat counters to 0; outputs hold.
- out  out  CHANNELS*CNT_W  latched count of the last complete window; channel i in bits [i*CNT_W +: CNT_W].
- out_valid  out  1  one-cycle pulse when out/overflow update.
- overflow  out  CHANNELS  channel saturated during the last complete window.

## Operation
- Per channel: SYNC_STAGES flop synchroniser, then optional debounce, then a registered level `lvl`; a beat is lvl rising (0→1).
- Beat counter: +1 per beat, saturates at 2^CNT_W−1. A beat arriving at saturation sets a per-channel sticky `sat` flag.
- Window counter: counts 0..WINDOW_CYCLES−1, then wraps. The terminal cycle is `wc == WINDOW_CYCLES−1`.
- On the terminal cycle:
  - out ← beat count including any beat detected in that same cycle (saturated).
  - overflow ← sat OR (saturating beat that cycle).
  - Beat counters and sat → 0.
  - The next window starts clean.
- clear: takes priority over the terminal cycle.
  - Window counter, beat counters and sat → 0.
  - No out_valid; out and overflow hold.
  - A beat detected in the clear cycle is dropped.
- Reset (asserted low, any time): all flops → 0.
  - out, overflow and out_valid read 0.
  - Synchroniser and lvl also read 0, so an input held high through reset release counts as one beat.
- Window counter width is $clog2(WINDOW_CYCLES). Beat counters never wrap.

## Timing
- Input to lvl latency: SYNC_STAGES+1 cycles without debounce; SYNC_STAGES+DEB_CYCLES+1 cycles with debounce.
- Beat counter increments in the cycle after lvl rises.
- out and overflow are registered. They change exactly one cycle after the terminal cycle, in the same cycle out_valid = 1.
- out_valid is high for one cycle per window. Period is WINDOW_CYCLES cycles after reset or clear release.
- First out_valid comes WINDOW_CYCLES cycles after reset deassertion, or after the last cycle clear was high.
- Minimum countable pulse: high ≥1 cycle and low ≥1 cycle after synchronisation (plus DEB_CYCLES each way with debounce).

## Configuration
- HARTSLAG_DEBOUNCE_EN defined:
  - Each channel has a counter that tracks how long the synchronised level has been stable.
  - lvl takes the new level only after DEB_CYCLES consecutive equal samples.
  - Any change resets the stability counter.
- Not defined: lvl = last synchroniser stage. DEB_CYCLES is ignored and no debounce logic is instantiated.

## Structure
- Package hartslag_pkg holds:
  - default parameter constants (WINDOW_CYCLES for 50 MHz, CNT_W, DEB_CYCLES);
  - a function computing the counter width from WINDOW_CYCLES.
- Sub-module hartslag_kanaal: one channel (synchroniser, optional debounce, edge detect, saturating counter, sat flag).
  - Instantiated CHANNELS times via generate.
  - Driven by shared `term` and `clear` strobes from the top.
- Top level holds the window counter, the output registers and out_valid.

## Test plan
All scenarios use CHANNELS=2, CNT_W=4, WINDOW_CYCLES=100, SYNC_STAGES=2, DEB_CYCLES=4.
- 7 clean pulses (5 high/5 low) on ch0, none on ch1, within the first window → out_valid at cycle 100 after reset release; out ch0=7, ch1=0; overflow=00.
- 20 pulses on ch1 in one window → out ch1=15, overflow[1]=1. The next window with 3 pulses → ch1=3, overflow[1]=0.
- Pulse whose edge is detected exactly on the terminal cycle → counted in the closing window; the next window starts at 0.
- clear asserted at cycle 60 with ch0 count 4 → no out_valid at cycle 100; next out_valid at cycle 160 (count covers only post-clear beats); out holds its previous value until then.
- Reset asserted mid-window (cycle 50, ch0 count 3) → out, overflow and out_valid are 0 immediately. After release, the first out_valid comes 100 cycles later.
- With HARTSLAG_DEBOUNCE_EN: 2-cycle glitches → count 0; 10-cycle pulses → counted. Without the macro, the same 2-cycle glitches are counted.
